// File: rtl/adc_channel_scheduler.sv
// Frame scheduler sharing one ADC and one distance LUT between NUM_CH IR sensors.
// Each period tick converts channels 0..NUM_CH-1 in turn and latches each LUT distance.
module adc_channel_scheduler #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned SAMPLE_PERIOD = 100000,
  parameter int unsigned ADC_TIMEOUT   = 4096,
  parameter int unsigned LUT_LATENCY   = 1,
  localparam int unsigned CHW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  err_clr_i,
  output logic                  adc_start_o,
  output logic [CHW-1:0]        adc_mux_sel_o,
  input  logic                  adc_done_i,
  input  logic [15:0]           adc_data_i,
  output logic [15:0]           lut_raw_adc_o,
  input  logic [6:0]            lut_distance_cm_i,
  output logic [NUM_CH*7-1:0]   dist_cm_o,
  output logic [NUM_CH-1:0]     dist_valid_o,
  output logic                  frame_done_o,
  output logic                  adc_timeout_err_o,
  output logic                  frame_overrun_o
);

  localparam int unsigned CNT_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned WAIT_MAX = (ADC_TIMEOUT > LUT_LATENCY) ? ADC_TIMEOUT : LUT_LATENCY;
  localparam int unsigned WCNT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned DIST_W   = 7;
  localparam int unsigned RAW_W    = 16;

  localparam logic [CNT_W-1:0]  PER_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [WCNT_W-1:0] TO_LAST  = WCNT_W'(ADC_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] LUT_LAST = WCNT_W'(LUT_LATENCY - 1);
  localparam logic [CHW-1:0]    CH_LAST  = CHW'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ADC,
    S_LUT_WAIT,
    S_STORE
  } state_e;

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 per_q, per_d;
  logic [CHW-1:0]                   ch_q, ch_d;
  logic [WCNT_W-1:0]                wcnt_q, wcnt_d;
  logic                             adc_start_q, adc_start_d;
  logic [CHW-1:0]                   mux_q, mux_d;
  logic [RAW_W-1:0]                 raw_q, raw_d;
  logic [NUM_CH-1:0][DIST_W-1:0]    dist_q, dist_d;
  logic [NUM_CH-1:0]                valid_q, valid_d;
  logic                             frame_done_q, frame_done_d;
  logic                             to_err_q, to_err_d;
  logic                             ovr_q, ovr_d;

  logic tick_c;
  logic advance_c;
  logic to_evt_c;
  logic ovr_evt_c;

  // Period counter: free-runs while enabled, parked at 0 otherwise.
  assign tick_c = enable_i && (per_q == PER_LAST);

  always_comb begin
    per_d = per_q;
    if (!enable_i) begin
      per_d = '0;
    end else if (per_q == PER_LAST) begin
      per_d = '0;
    end else begin
      per_d = per_q + CNT_W'(1);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    wcnt_d       = wcnt_q;
    adc_start_d  = 1'b0;
    mux_d        = mux_q;
    raw_d        = raw_q;
    dist_d       = dist_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    to_err_d     = to_err_q;
    ovr_d        = ovr_q;
    advance_c    = 1'b0;
    to_evt_c     = 1'b0;
    ovr_evt_c    = tick_c && (state_q != S_IDLE);

    if (!enable_i) begin
      // Abort: the in-flight channel is dropped without touching its results.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (tick_c) begin
            ch_d    = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          wcnt_d  = '0;
          state_d = S_WAIT_ADC;
        end
        S_WAIT_ADC: begin
          if (adc_done_i) begin
            raw_d   = adc_data_i;
            wcnt_d  = '0;
            state_d = S_LUT_WAIT;
          end else if (wcnt_q == TO_LAST) begin
            to_evt_c      = 1'b1;
            valid_d[ch_q] = 1'b0;
            advance_c     = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
        S_LUT_WAIT: begin
          if (wcnt_q == LUT_LAST) begin
            state_d = S_STORE;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
        S_STORE: begin
          dist_d[ch_q]  = lut_distance_cm_i;
          valid_d[ch_q] = 1'b1;
          advance_c     = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (advance_c) begin
        if (ch_q == CH_LAST) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = S_START;
        end
      end
    end

    // The start strobe and mux select are launched together on entry to START.
    if (state_d == S_START) begin
      adc_start_d = 1'b1;
      mux_d       = ch_d;
    end

    // Sticky flags: a new event outranks a simultaneous clear.
    if (to_evt_c) begin
      to_err_d = 1'b1;
    end else if (err_clr_i) begin
      to_err_d = 1'b0;
    end

    if (ovr_evt_c) begin
      ovr_d = 1'b1;
    end else if (err_clr_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      per_q        <= '0;
      ch_q         <= '0;
      wcnt_q       <= '0;
      adc_start_q  <= 1'b0;
      mux_q        <= '0;
      raw_q        <= '0;
      dist_q       <= '0;
      valid_q      <= '0;
      frame_done_q <= 1'b0;
      to_err_q     <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      ch_q         <= ch_d;
      wcnt_q       <= wcnt_d;
      adc_start_q  <= adc_start_d;
      mux_q        <= mux_d;
      raw_q        <= raw_d;
      dist_q       <= dist_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      to_err_q     <= to_err_d;
      ovr_q        <= ovr_d;
    end
  end

  assign adc_start_o       = adc_start_q;
  assign adc_mux_sel_o     = mux_q;
  assign lut_raw_adc_o     = raw_q;
  assign dist_cm_o         = dist_q;
  assign dist_valid_o      = valid_q;
  assign frame_done_o      = frame_done_q;
  assign adc_timeout_err_o = to_err_q;
  assign frame_overrun_o   = ovr_q;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench for adc_channel_scheduler with a delayed-pulse ADC model and a registered LUT.
// A second instance with a short period exercises the overrun path.
module tb_adc_channel_scheduler;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned SP     = 40;
  localparam int unsigned TO     = 8;
  localparam int unsigned LL     = 1;
  localparam int unsigned SP2    = 16;
  localparam int unsigned CHW    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic enable, err_clr;
  logic adc_start;
  logic [CHW-1:0] adc_mux_sel;
  logic adc_done;
  logic [15:0] adc_data;
  logic [15:0] lut_raw;
  logic [6:0]  lut_dist = 7'd0;
  logic [NUM_CH*7-1:0] dist_cm;
  logic [NUM_CH-1:0]   dist_valid;
  logic frame_done, adc_timeout_err, frame_overrun;

  logic en2, clr2;
  logic o2_start;
  logic [CHW-1:0] o2_mux;
  logic [15:0] o2_raw;
  logic [NUM_CH*7-1:0] o2_dist;
  logic [NUM_CH-1:0] o2_valid;
  logic o2_fd, o2_err, o2_ovr;

  adc_channel_scheduler #(
    .NUM_CH(NUM_CH), .SAMPLE_PERIOD(SP), .ADC_TIMEOUT(TO), .LUT_LATENCY(LL)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .err_clr_i(err_clr),
    .adc_start_o(adc_start), .adc_mux_sel_o(adc_mux_sel),
    .adc_done_i(adc_done), .adc_data_i(adc_data),
    .lut_raw_adc_o(lut_raw), .lut_distance_cm_i(lut_dist),
    .dist_cm_o(dist_cm), .dist_valid_o(dist_valid), .frame_done_o(frame_done),
    .adc_timeout_err_o(adc_timeout_err), .frame_overrun_o(frame_overrun)
  );

  // Silent-ADC instance whose frames outlast its period.
  adc_channel_scheduler #(
    .NUM_CH(NUM_CH), .SAMPLE_PERIOD(SP2), .ADC_TIMEOUT(TO), .LUT_LATENCY(LL)
  ) u_ovr (
    .clk(clk), .rst_n(rst_n), .enable_i(en2), .err_clr_i(clr2),
    .adc_start_o(o2_start), .adc_mux_sel_o(o2_mux),
    .adc_done_i(1'b0), .adc_data_i(16'h0000),
    .lut_raw_adc_o(o2_raw), .lut_distance_cm_i(7'd0),
    .dist_cm_o(o2_dist), .dist_valid_o(o2_valid), .frame_done_o(o2_fd),
    .adc_timeout_err_o(o2_err), .frame_overrun_o(o2_ovr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC model: pulses adc_done delay_cyc[ch] cycles after the adc_start cycle.
  int          delay_cyc [NUM_CH];
  logic [15:0] data_v    [NUM_CH];
  bit          silent    [NUM_CH];
  logic        armed;
  int          cd;
  logic [CHW-1:0] m_ch;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      cd       <= 0;
      m_ch     <= '0;
      adc_done <= 1'b0;
      adc_data <= 16'h0000;
    end else begin
      adc_done <= 1'b0;
      if (armed && cd == 1) begin
        adc_done <= 1'b1;
        adc_data <= data_v[m_ch];
        armed    <= 1'b0;
      end else if (armed) begin
        cd <= cd - 1;
      end
      if (adc_start) begin
        armed <= !silent[adc_mux_sel];
        cd    <= delay_cyc[adc_mux_sel] - 1;
        m_ch  <= adc_mux_sel;
      end
    end
  end

  function automatic logic [6:0] lut_map(input logic [15:0] r);
    case (r)
      16'h4000: lut_map = 7'd12;
      16'h2000: lut_map = 7'd30;
      16'h1000: lut_map = 7'd50;
      16'h3000: lut_map = 7'd20;
      default:  lut_map = 7'd127;
    endcase
  endfunction

  always @(posedge clk) lut_dist <= lut_map(lut_raw);

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  int fd_cnt = 0;
  int start_cyc = 0;
  int fd_cyc = 0;
  logic [CHW-1:0] mux_hist[$];

  always @(negedge clk) begin
    cyc++;
    if (adc_start) begin
      start_cyc = cyc;
      mux_hist.push_back(adc_mux_sel);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frame(input int bound, output bit seen);
    int f0;
    f0   = fd_cnt;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (fd_cnt != f0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_start(input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (adc_start) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, 32'(adc_start), 32'd0);
    check({tag, "_mux"},   32'(adc_mux_sel), 32'd0);
    check({tag, "_raw"},   32'(lut_raw), 32'd0);
    check({tag, "_dist"},  32'(dist_cm), 32'd0);
    check({tag, "_valid"}, 32'(dist_valid), 32'd0);
    check({tag, "_fd"},    32'(frame_done), 32'd0);
    check({tag, "_err"},   32'(adc_timeout_err), 32'd0);
    check({tag, "_ovr"},   32'(frame_overrun), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    int fd_before;
    int st_before;
    logic [13:0] exp_dist;

    enable = 1'b0; err_clr = 1'b0; en2 = 1'b0; clr2 = 1'b0;
    delay_cyc[0] = 3; delay_cyc[1] = 3;
    data_v[0] = 16'h4000; data_v[1] = 16'h2000;
    silent[0] = 1'b0; silent[1] = 1'b0;

    repeat (3) step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    // First start strobe lands on the 40th enabled cycle.
    enable = 1'b1;
    wait_start(100, n);
    check("first_start_cycle", 32'(n), 32'd40);
    check("first_start_mux", 32'(adc_mux_sel), 32'd0);

    // Normal frame.
    wait_frame(200, seen);
    check("t2_seen", 32'(seen), 32'd1);
    exp_dist = {7'd30, 7'd12};
    check("t2_dist", 32'(dist_cm), 32'(exp_dist));
    check("t2_valid", 32'(dist_valid), 32'd3);
    check("t2_mux0", 32'(mux_hist[mux_hist.size()-2]), 32'd0);
    check("t2_mux1", 32'(mux_hist[mux_hist.size()-1]), 32'd1);
    check("t2_fd_latency", 32'(fd_cyc - start_cyc), 32'd6);
    check("t2_err", 32'(adc_timeout_err), 32'd0);
    step();
    check("t2_fd_pulse", 32'(frame_done), 32'd0);
    check("t2_fd_count", 32'(fd_cnt), 32'd1);
    check("t2_ovr", 32'(frame_overrun), 32'd0);

    // Channel 1 silent: timeout after 8 WAIT_ADC cycles.
    silent[1] = 1'b1;
    data_v[0] = 16'h1000;
    wait_frame(200, seen);
    check("t3_seen", 32'(seen), 32'd1);
    check("t3_err", 32'(adc_timeout_err), 32'd1);
    check("t3_valid", 32'(dist_valid), 32'd1);
    exp_dist = {7'd30, 7'd50};
    check("t3_dist", 32'(dist_cm), 32'(exp_dist));
    check("t3_fd_latency", 32'(fd_cyc - start_cyc), 32'd9);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t3_err_clr", 32'(adc_timeout_err), 32'd0);

    // adc_done on the timeout cycle itself is accepted.
    silent[1] = 1'b0;
    delay_cyc[1] = 8;
    data_v[0] = 16'h4000;
    data_v[1] = 16'h3000;
    wait_frame(200, seen);
    check("t6_seen", 32'(seen), 32'd1);
    exp_dist = {7'd20, 7'd12};
    check("t6_dist", 32'(dist_cm), 32'(exp_dist));
    check("t6_valid", 32'(dist_valid), 32'd3);
    check("t6_err", 32'(adc_timeout_err), 32'd0);
    check("t6_fd_latency", 32'(fd_cyc - start_cyc), 32'd11);

    // enable drops during ch0 WAIT_ADC; the late adc_done must be ignored.
    delay_cyc[1] = 3;
    delay_cyc[0] = 6;
    data_v[0] = 16'h1000;
    wait_start(100, n);
    check("t5_start_seen", 32'(n != 0), 32'd1);
    step();
    step();
    enable = 1'b0;
    fd_before = fd_cnt;
    st_before = start_cyc;
    repeat (20) step();
    check("t5_dist", 32'(dist_cm), 32'(exp_dist));
    check("t5_valid", 32'(dist_valid), 32'd3);
    check("t5_raw_hold", 32'(lut_raw), 32'h3000);
    check("t5_mux_hold", 32'(adc_mux_sel), 32'd0);
    check("t5_no_fd", 32'(fd_cnt - fd_before), 32'd0);
    check("t5_no_restart", 32'(start_cyc - st_before), 32'd0);
    check("t5_err", 32'(adc_timeout_err), 32'd0);

    // Re-enable: period counter restarted from 0.
    delay_cyc[0] = 3;
    enable = 1'b1;
    wait_start(100, n);
    check("t5_restart_cycle", 32'(n), 32'd40);
    wait_frame(200, seen);
    check("t5_frame_seen", 32'(seen), 32'd1);
    exp_dist = {7'd20, 7'd50};
    check("t5_frame_dist", 32'(dist_cm), 32'(exp_dist));

    // Asynchronous reset in the middle of a conversion.
    wait_start(100, n);
    check("t1_mid_start_seen", 32'(n != 0), 32'd1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    step();
    rst_n = 1'b1;
    enable = 1'b0;
    step();

    // Overrun: 18-cycle timed-out frames against a 16-cycle period.
    en2 = 1'b1;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (o2_start) begin
        n = i;
        break;
      end
    end
    check("t4_first_start", 32'(n), 32'd16);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (o2_start && o2_mux == 1'b0) begin
        n = i;
        break;
      end
    end
    check("t4_next_frame_gap", 32'(n), 32'd32);
    check("t4_ovr", 32'(o2_ovr), 32'd1);
    check("t4_err", 32'(o2_err), 32'd1);
    check("t4_valid", 32'(o2_valid), 32'd0);
    check("t4_raw", 32'(o2_raw), 32'd0);
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    check("t4_ovr_clr", 32'(o2_ovr), 32'd0);
    check("t4_err_clr", 32'(o2_err), 32'd0);
    en2 = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
